// File: rtl/dsp_mac_feeder_if.sv
// ---------------------------------------------------------------------------
// dsp_mac_feeder_if
//
// Purpose: bundles the two handshakes of dsp_mac_feeder: the operand-pair
// stream (s_*) and the accumulation-result stream (res_*).
//
// Handshake rule for both streams: a transfer happens on a rising CLK edge
// where valid and ready are both high. A producer that raises valid keeps
// it high, with its payload stable, until that transfer. ready may change
// freely and never depends combinationally on valid.
//
// Signals:
//   s_valid   operand pair valid               (master -> slave)
//   s_ready   operand pair accepted            (slave  -> master)
//   s_a       signed 18-bit multiplicand       (master -> slave)
//   s_b       signed 18-bit multiplier         (master -> slave)
//   res_valid result available                 (slave  -> master)
//   res_ready result consumed                  (master -> slave)
//   res_data  48-bit accumulation result       (slave  -> master)
//
// Modports:
//   master  the side that supplies operands and consumes results
//   slave   the feeder itself
// ---------------------------------------------------------------------------
interface dsp_mac_feeder_if;
    logic        s_valid;
    logic        s_ready;
    logic [17:0] s_a;
    logic [17:0] s_b;
    logic        res_valid;
    logic        res_ready;
    logic [47:0] res_data;

    modport master (
        output s_valid, s_a, s_b, res_ready,
        input  s_ready, res_valid, res_data
    );

    modport slave (
        input  s_valid, s_a, s_b, res_ready,
        output s_ready, res_valid, res_data
    );
endinterface

// File: rtl/dsp_mac_feeder.sv
// ---------------------------------------------------------------------------
// dsp_mac_feeder
//
// Purpose: operand sequencer in front of a DSP48A1 slice. It accepts a
// programmed number of signed 18-bit A/B pairs and drives the slice's A, B
// and OPMODE inputs so that the slice accumulates the products. Once the
// last product has worked its way through the slice pipeline, it captures
// the slice's P output and offers it on the result handshake.
//
// Parameters:
//   CNT_W    width of the term counter (max terms per job = 2^CNT_W - 1)
//   P_LAT    cycles from an A/B register update to the matching valid P
//   OPM_DLY  extra cycles OPMODE lags A/B for the same slot (>= 1)
//
// Ports:
//   CLK         clock, rising edge
//   RST         synchronous active-high reset
//   start       job request, only looked at in IDLE
//   len         number of terms, sampled together with start
//   io          slave side of the operand and result handshakes
//   dsp_A       slice A input (registered)
//   dsp_B       slice B input (registered)
//   dsp_OPMODE  slice OPMODE input (delayed by OPM_DLY stages)
//   dsp_P       slice P output
//   busy        high whenever the FSM is not in IDLE
//   dbg_state   current FSM state encoding (IDLE=0, ISSUE=1, DRAIN=2, HOLD=3)
// ---------------------------------------------------------------------------
module dsp_mac_feeder #(
    parameter int CNT_W   = 8,
    parameter int P_LAT   = 4,
    parameter int OPM_DLY = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    dsp_mac_feeder_if.slave   io,
    output logic [17:0]       dsp_A,
    output logic [17:0]       dsp_B,
    output logic [7:0]        dsp_OPMODE,
    input  logic [47:0]       dsp_P,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // X=M, Z=0: starts a fresh sum with the current product.
    localparam logic [7:0] OPM_FIRST = 8'h01;
    // X=M, Z=P: adds the current product to the running sum.
    localparam logic [7:0] OPM_ACC   = 8'h09;

    localparam int DRN_W = $clog2(P_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   rem_q,       rem_d;
    logic [DRN_W-1:0]   drain_q,     drain_d;
    logic               first_q,     first_d;
    logic [17:0]        dsp_a_q,     dsp_a_d;
    logic [17:0]        dsp_b_q,     dsp_b_d;
    logic [7:0]         slot_opm_q,  slot_opm_d;
    logic [7:0]         opm_pipe_q [OPM_DLY];
    logic [7:0]         opm_pipe_d [OPM_DLY];
    logic               res_valid_q, res_valid_d;
    logic [47:0]        res_data_q,  res_data_d;

    logic               s_ready;
    logic               accept;

    // s_ready comes straight from the state register, so it never depends
    // on s_valid in the same cycle.
    assign s_ready = (state_q == ST_ISSUE);
    assign accept  = s_ready && io.s_valid;

    // -----------------------------------------------------------------------
    // Next-state and slot generation
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        drain_d     = drain_q;
        first_d     = first_q;
        dsp_a_d     = '0;
        dsp_b_d     = '0;
        slot_opm_d  = OPM_ACC;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        unique case (state_q)
            ST_IDLE: begin
                // A zero-length job has nothing to accumulate: ignore it.
                if (start && (len != '0)) begin
                    rem_d   = len;
                    first_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // A bubble still issues a slot with a zero product. While no
                // term has been taken it uses FIRST, so the accumulator is
                // cleared rather than carrying a previous job's P.
                slot_opm_d = first_q ? OPM_FIRST : OPM_ACC;
                if (accept) begin
                    dsp_a_d = io.s_a;
                    dsp_b_d = io.s_b;
                    first_d = 1'b0;
                    rem_d   = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        drain_d = DRN_W'(P_LAT);
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // Counts P_LAT edges after the last accept; at the final one
                // dsp_P holds the complete sum.
                drain_d = drain_q - DRN_W'(1);
                if (drain_q == DRN_W'(1)) begin
                    res_data_d  = dsp_P;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (io.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // OPMODE follows its slot by OPM_DLY stages so it meets the product at
    // the slice's OPMODE register in the same cycle the M register does.
    always_comb begin
        opm_pipe_d[0] = slot_opm_q;
        for (int i = 1; i < OPM_DLY; i++) begin
            opm_pipe_d[i] = opm_pipe_q[i-1];
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            drain_q     <= '0;
            first_q     <= 1'b0;
            dsp_a_q     <= '0;
            dsp_b_q     <= '0;
            slot_opm_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            for (int i = 0; i < OPM_DLY; i++) begin
                opm_pipe_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            drain_q     <= drain_d;
            first_q     <= first_d;
            dsp_a_q     <= dsp_a_d;
            dsp_b_q     <= dsp_b_d;
            slot_opm_q  <= slot_opm_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            opm_pipe_q  <= opm_pipe_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign io.s_ready    = s_ready;
    assign io.res_valid  = res_valid_q;
    assign io.res_data   = res_data_q;
    assign dsp_A         = dsp_a_q;
    assign dsp_B         = dsp_b_q;
    assign dsp_OPMODE    = opm_pipe_q[OPM_DLY-1];
    assign busy          = (state_q != ST_IDLE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_dsp_mac_feeder.sv
// ---------------------------------------------------------------------------
// tb_dsp_mac_feeder
//
// Directed bench for dsp_mac_feeder. A behavioural DSP48A1 (A1/B1, M,
// OPMODE and P registers, reset by RST) closes the loop on dsp_P. Inputs are
// driven 1 ns after each rising edge; outputs are checked at the same point.
// ---------------------------------------------------------------------------
module tb_dsp_mac_feeder;

    logic        CLK;
    logic        RST;
    logic        start;
    logic [7:0]  len;
    logic [17:0] dsp_A;
    logic [17:0] dsp_B;
    logic [7:0]  dsp_OPMODE;
    logic [47:0] dsp_P;
    logic        busy;
    logic [1:0]  dbg_state;

    int vectors;
    int miscompares;

    dsp_mac_feeder_if io ();

    dsp_mac_feeder #(
        .CNT_W   (8),
        .P_LAT   (4),
        .OPM_DLY (1)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .len        (len),
        .io         (io),
        .dsp_A      (dsp_A),
        .dsp_B      (dsp_B),
        .dsp_OPMODE (dsp_OPMODE),
        .dsp_P      (dsp_P),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- DSP48A1 behavioural slice ----------------
    logic [17:0]        a1_r;
    logic [17:0]        b1_r;
    logic signed [35:0] m_r;
    logic [7:0]         opm_r;
    logic [47:0]        p_r;
    logic [47:0]        x_mux;
    logic [47:0]        z_mux;

    always_comb begin
        x_mux = (opm_r[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'd0;
        z_mux = (opm_r[3:2] == 2'b10) ? p_r : 48'd0;
    end

    always @(posedge CLK) begin
        if (RST) begin
            a1_r  <= '0;
            b1_r  <= '0;
            m_r   <= '0;
            opm_r <= '0;
            p_r   <= '0;
        end else begin
            a1_r  <= dsp_A;
            b1_r  <= dsp_B;
            m_r   <= $signed(a1_r) * $signed(b1_r);
            opm_r <= dsp_OPMODE;
            p_r   <= z_mux + x_mux;
        end
    end

    assign dsp_P = p_r;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [7:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
        len   = '0;
    endtask

    // Presents one pair and returns just after the edge that accepted it.
    // s_valid is left high; the caller lowers it when a bubble is wanted.
    task automatic send_pair(input logic [17:0] a, input logic [17:0] b);
        int n;
        io.s_valid = 1'b1;
        io.s_a     = a;
        io.s_b     = b;
        n = 0;
        while (!io.s_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("accept_timeout", 48'd0, 48'd1);
        tick();
    endtask

    // Called just after the last accept: checks result latency and data,
    // then completes the result handshake.
    task automatic take_result(input string tag, input logic [47:0] exp);
        int n;
        io.s_valid = 1'b0;
        n = 0;
        while (!io.res_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 48'(n), 48'd4);
        check({tag, "_data"}, io.res_data, exp);
        io.res_ready = 1'b1;
        tick();
        io.res_ready = 1'b0;
        check({tag, "_idle_busy"}, {47'd0, busy}, 48'd0);
        check({tag, "_idle_res_valid"}, {47'd0, io.res_valid}, 48'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        vectors      = 0;
        miscompares  = 0;
        RST          = 1'b1;
        start        = 1'b0;
        len          = '0;
        io.s_valid   = 1'b0;
        io.s_a       = '0;
        io.s_b       = '0;
        io.res_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_s_ready",   {47'd0, io.s_ready},   48'd0);
        check("rst_busy",      {47'd0, busy},         48'd0);
        check("rst_res_valid", {47'd0, io.res_valid}, 48'd0);
        check("rst_res_data",  io.res_data,           48'd0);
        check("rst_dsp_A",     {30'd0, dsp_A},        48'd0);
        check("rst_dsp_B",     {30'd0, dsp_B},        48'd0);
        check("rst_opmode",    {40'd0, dsp_OPMODE},   48'd0);
        RST = 1'b0;
        repeat (2) tick();

        // Basic: (20,10),(5,6),(-3,7) back to back -> 209
        start_job(8'd3);
        check("basic_busy",    {47'd0, busy},       48'd1);
        check("basic_s_ready", {47'd0, io.s_ready}, 48'd1);
        send_pair(18'd20, 18'd10);
        check("basic_dsp_A0",  {30'd0, dsp_A},      48'd20);
        check("basic_dsp_B0",  {30'd0, dsp_B},      48'd10);
        send_pair(18'd5, 18'd6);
        check("basic_dsp_A1",  {30'd0, dsp_A},      48'd5);
        check("basic_opm0",    {40'd0, dsp_OPMODE}, 48'h01);
        send_pair(18'h3FFFD, 18'd7);
        check("basic_dsp_A2",  {30'd0, dsp_A},      48'h3FFFD);
        check("basic_opm1",    {40'd0, dsp_OPMODE}, 48'h09);
        take_result("basic", 48'h0000_0000_00D1);

        // Bubbles: same job, 3 idle cycles first, 2 between pairs
        start_job(8'd3);
        io.s_valid = 1'b0;
        repeat (3) tick();
        send_pair(18'd20, 18'd10);
        io.s_valid = 1'b0;
        repeat (2) tick();
        send_pair(18'd5, 18'd6);
        io.s_valid = 1'b0;
        repeat (2) tick();
        send_pair(18'h3FFFD, 18'd7);
        take_result("bubble", 48'h0000_0000_00D1);

        // Sign: (-1) * 2 -> -2
        start_job(8'd1);
        send_pair(18'h3FFFF, 18'd2);
        take_result("sign_neg", 48'hFFFF_FFFF_FFFE);

        // Fresh job after a negative result, then hold off the result
        start_job(8'd1);
        send_pair(18'd5, 18'd6);
        io.s_valid = 1'b0;
        begin
            int n;
            n = 0;
            while (!io.res_valid && n < 40) begin
                tick();
                n++;
            end
            check("bp_latency", 48'(n), 48'd4);
        end
        start = 1'b1;
        len   = 8'd5;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_res_valid", {47'd0, io.res_valid}, 48'd1);
            check("bp_res_data",  io.res_data,           48'h1E);
            check("bp_s_ready",   {47'd0, io.s_ready},   48'd0);
        end
        start        = 1'b0;
        len          = '0;
        io.res_ready = 1'b1;
        tick();
        io.res_ready = 1'b0;
        check("bp_release_busy",      {47'd0, busy},         48'd0);
        check("bp_release_res_valid", {47'd0, io.res_valid}, 48'd0);
        tick();
        check("bp_no_restart", {47'd0, busy}, 48'd0);

        // Boundary: len=0 is ignored
        start_job(8'd0);
        check("len0_busy", {47'd0, busy}, 48'd0);
        tick();
        check("len0_busy_later",    {47'd0, busy},       48'd0);
        check("len0_s_ready_later", {47'd0, io.s_ready}, 48'd0);

        // Boundary: 255 terms of 1*1
        start_job(8'd255);
        for (int i = 0; i < 255; i++) begin
            send_pair(18'd1, 18'd1);
        end
        take_result("len255", 48'h0000_0000_00FF);

        // Reset mid-job after 2 of 4 terms
        start_job(8'd4);
        send_pair(18'd9, 18'd9);
        send_pair(18'd9, 18'd9);
        RST = 1'b1;
        tick();
        check("midrst_busy",      {47'd0, busy},         48'd0);
        check("midrst_s_ready",   {47'd0, io.s_ready},   48'd0);
        check("midrst_res_valid", {47'd0, io.res_valid}, 48'd0);
        check("midrst_opmode",    {40'd0, dsp_OPMODE},   48'd0);
        check("midrst_dsp_A",     {30'd0, dsp_A},        48'd0);
        RST        = 1'b0;
        io.s_valid = 1'b0;
        repeat (3) tick();
        check("midrst_no_result", {47'd0, io.res_valid}, 48'd0);

        start_job(8'd1);
        send_pair(18'd7, 18'd7);
        take_result("after_rst", 48'h0000_0000_0031);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
